// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: character codes, active-low a..g
// patterns and one-hot digit helpers. Used by both the scan decoder and the
// driver-side encoder.
package seg7_pkg;

    typedef logic [4:0] char_t;

    localparam char_t CH_0       = 5'h00;
    localparam char_t CH_1       = 5'h01;
    localparam char_t CH_2       = 5'h02;
    localparam char_t CH_3       = 5'h03;
    localparam char_t CH_4       = 5'h04;
    localparam char_t CH_5       = 5'h05;
    localparam char_t CH_6       = 5'h06;
    localparam char_t CH_7       = 5'h07;
    localparam char_t CH_8       = 5'h08;
    localparam char_t CH_9       = 5'h09;
    localparam char_t CH_E       = 5'h0A;
    localparam char_t CH_F       = 5'h0B;
    localparam char_t CH_N       = 5'h0C;
    localparam char_t CH_P       = 5'h0D;
    localparam char_t CH_R       = 5'h0E;
    localparam char_t CH_DASH    = 5'h0F;
    localparam char_t CH_BLANK   = 5'h10;
    localparam char_t CH_UNKNOWN = 5'h1F;

    // Segment patterns, bit6..bit0 = a..g, a 0 lights the segment.
    localparam logic [6:0] PAT_0     = 7'b0000001;
    localparam logic [6:0] PAT_1     = 7'b1001111;
    localparam logic [6:0] PAT_2     = 7'b0010010;
    localparam logic [6:0] PAT_3     = 7'b0000110;
    localparam logic [6:0] PAT_4     = 7'b1001100;
    localparam logic [6:0] PAT_5     = 7'b0100100;
    localparam logic [6:0] PAT_6     = 7'b0100000;
    localparam logic [6:0] PAT_7     = 7'b0001111;
    localparam logic [6:0] PAT_8     = 7'b0000000;
    localparam logic [6:0] PAT_9     = 7'b0000100;
    localparam logic [6:0] PAT_E     = 7'b0110000;
    localparam logic [6:0] PAT_F     = 7'b0111000;
    localparam logic [6:0] PAT_N     = 7'b0001001;
    localparam logic [6:0] PAT_P     = 7'b0011000;
    localparam logic [6:0] PAT_R     = 7'b1111010;
    localparam logic [6:0] PAT_DASH  = 7'b1111110;
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    // Position of the set bit; only meaningful for a one-hot argument.
    function automatic logic [1:0] onehot4_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup from an active-low a..g segment pattern to its
// 5-bit character code. Letter O shares the pattern of digit 0.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output char_t      code_o
);

    // Pattern table; anything not in the character set is UNKNOWN.
    always_comb begin
        code_o = CH_UNKNOWN;
        case (pattern_i)
            PAT_0:     code_o = CH_0;
            PAT_1:     code_o = CH_1;
            PAT_2:     code_o = CH_2;
            PAT_3:     code_o = CH_3;
            PAT_4:     code_o = CH_4;
            PAT_5:     code_o = CH_5;
            PAT_6:     code_o = CH_6;
            PAT_7:     code_o = CH_7;
            PAT_8:     code_o = CH_8;
            PAT_9:     code_o = CH_9;
            PAT_E:     code_o = CH_E;
            PAT_F:     code_o = CH_F;
            PAT_N:     code_o = CH_N;
            PAT_P:     code_o = CH_P;
            PAT_R:     code_o = CH_R;
            PAT_DASH:  code_o = CH_DASH;
            PAT_BLANK: code_o = CH_BLANK;
            default:   code_o = CH_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of the multiplexed 4-digit seven-segment bus. Registers the
// scan bus, accepts a digit slot once its (digit, a..g) pair has been stable
// long enough to rule out ghosting, decodes it, and publishes a 4-character
// frame once every slot has been accepted. Flags a stalled scan.
module seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 200_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  digit_in,
    output logic [19:0] chars,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        bad_pattern,
    output logic        scan_stall
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    // Decimal point carries no character information.
    logic unused_dp;
    assign unused_dp = seg_in[0];

    logic [6:0]    seg_q;
    logic [3:0]    digit_q;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d;
    logic          accepted_q, accepted_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          stall_q, stall_d;
    logic [3:0]    mask_q, mask_d;
    char_t         stage_q [4];
    char_t         stage_d [4];
    logic [19:0]   chars_q, chars_d;
    logic          fv_q, fv_d;
    logic          fc_q, fc_d;
    logic          bp_q, bp_d;

    logic          in_onehot;
    logic          same_pair;
    logic          accept;
    logic [1:0]    slot;
    char_t         code;

    // The incoming sample is compared with the one already held so that the
    // count includes the sample being registered on this edge.
    assign in_onehot = is_onehot4(digit_in);
    assign same_pair = (digit_in == digit_q) && (seg_in[7:1] == seg_q);
    assign slot      = onehot4_index(digit_q);

    seg7_pattern_decode u_decode (
        .pattern_i (seg_q),
        .code_o    (code)
    );

    // Stability counter and once-per-dwell acceptance.
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        accepted_d = accepted_q;
        accept     = 1'b0;
        if (!in_onehot) begin
            stab_cnt_d = '0;
            accepted_d = 1'b0;
        end else if (!same_pair) begin
            stab_cnt_d = SW'(1);
            accepted_d = 1'b0;
        end else begin
            if (stab_cnt_q != STABLE_MAX) stab_cnt_d = stab_cnt_q + SW'(1);
            if ((stab_cnt_d == STABLE_MAX) && !accepted_q) begin
                accept     = 1'b1;
                accepted_d = 1'b1;
            end
        end
    end

    // Staging, slot mask, frame publication and stall timeout.
    always_comb begin
        stage_d  = stage_q;
        mask_d   = mask_q;
        chars_d  = chars_q;
        fv_d     = 1'b0;
        fc_d     = 1'b0;
        bp_d     = 1'b0;
        to_cnt_d = to_cnt_q;
        stall_d  = stall_q;
        if (accept) begin
            stage_d[slot] = code;
            mask_d        = mask_q | (4'b0001 << slot);
            to_cnt_d      = '0;
            stall_d       = 1'b0;
            bp_d          = (code == CH_UNKNOWN);
            if (mask_d == 4'b1111) begin
                chars_d = {stage_d[3], stage_d[2], stage_d[1], stage_d[0]};
                fv_d    = 1'b1;
                fc_d    = (chars_d != chars_q);
                mask_d  = 4'b0000;
            end
        end else begin
            if (to_cnt_q != TIMEOUT_MAX) to_cnt_d = to_cnt_q + TW'(1);
            if (to_cnt_d == TIMEOUT_MAX) begin
                stall_d = 1'b1;
                mask_d  = 4'b0000;
            end
        end
    end

    // Control and published state; reset overrides every update.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q      <= '0;
            digit_q    <= '0;
            stab_cnt_q <= '0;
            accepted_q <= 1'b0;
            to_cnt_q   <= '0;
            stall_q    <= 1'b0;
            mask_q     <= '0;
            chars_q    <= {4{CH_BLANK}};
            fv_q       <= 1'b0;
            fc_q       <= 1'b0;
            bp_q       <= 1'b0;
        end else begin
            seg_q      <= seg_in[7:1];
            digit_q    <= digit_in;
            stab_cnt_q <= stab_cnt_d;
            accepted_q <= accepted_d;
            to_cnt_q   <= to_cnt_d;
            stall_q    <= stall_d;
            mask_q     <= mask_d;
            chars_q    <= chars_d;
            fv_q       <= fv_d;
            fc_q       <= fc_d;
            bp_q       <= bp_d;
        end
    end

    // Staging entries are only read once all four slots are rewritten.
    always_ff @(posedge clk) begin
        stage_q <= stage_d;
    end

    assign chars         = chars_q;
    assign frame_valid   = fv_q;
    assign frame_changed = fc_q;
    assign bad_pattern   = bp_q;
    assign scan_stall    = stall_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomised and directed bench for seg_scan_decoder against a behavioural
// model of the scan-bus protocol.
module tb_seg_scan_decoder;

    localparam int S = 4;
    localparam int T = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg_in;
    logic [3:0]  digit_in;
    logic [19:0] chars;
    logic        frame_valid;
    logic        frame_changed;
    logic        bad_pattern;
    logic        scan_stall;

    seg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .seg_in        (seg_in),
        .digit_in      (digit_in),
        .chars         (chars),
        .frame_valid   (frame_valid),
        .frame_changed (frame_changed),
        .bad_pattern   (bad_pattern),
        .scan_stall    (scan_stall)
    );

    always #10 clk = ~clk;

    // Character table: active-low a..g pattern and its code.
    localparam logic [6:0] PATS  [17] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                          7'b0000000, 7'b0000100, 7'b0110000, 7'b0111000,
                                          7'b0001001, 7'b0011000, 7'b1111010, 7'b1111110,
                                          7'b1111111};
    localparam logic [4:0] CODES [17] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06,
                                          5'h07, 5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D,
                                          5'h0E, 5'h0F, 5'h10};

    localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110, PE = 7'b0110000, PF = 7'b0111000;
    localparam logic [6:0] PN = 7'b0001001, PR = 7'b1111010, PD = 7'b1111110;
    localparam logic [6:0] PB = 7'b1111111, PX = 7'b1010101;

    int n_vec = 0;
    int n_err = 0;

    // Model state: run length of identical input samples, idle time since the
    // last accepted slot, collected slots and the published frame.
    int         m_run;
    logic [3:0] m_prev_d;
    logic [6:0] m_prev_s;
    int         m_idle;
    bit         m_stall;
    logic [4:0] m_stage [4];
    bit   [3:0] m_mask;
    logic [19:0] m_chars;
    bit         m_fv, m_fc, m_bp;

    int fv_seen, fc_seen, bp_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 17; i++) begin
            if (PATS[i] == p) return CODES[i];
        end
        return 5'h1F;
    endfunction

    task automatic model_edge(input logic r, input logic [3:0] d, input logic [6:0] p);
        bit oh;
        int idx;
        logic [4:0] c;
        logic [19:0] nf;
        m_fv = 0; m_fc = 0; m_bp = 0;
        if (r) begin
            m_run = 0; m_prev_d = 4'h0; m_prev_s = 7'h00;
            m_idle = 0; m_stall = 0; m_mask = 4'h0;
            m_chars = {4{5'h10}};
            return;
        end
        oh = ($countones(d) == 1);
        if (!oh) m_run = 0;
        else if (d == m_prev_d && p == m_prev_s) m_run++;
        else m_run = 1;
        m_prev_d = d;
        m_prev_s = p;
        if (oh && m_run == S) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (d[i]) idx = i;
            c = ref_decode(p);
            m_stage[idx] = c;
            m_mask[idx] = 1'b1;
            m_idle = 0;
            m_stall = 0;
            m_bp = (c == 5'h1F);
            if (m_mask == 4'hF) begin
                nf = {m_stage[3], m_stage[2], m_stage[1], m_stage[0]};
                m_fc = (nf != m_chars);
                m_chars = nf;
                m_fv = 1;
                m_mask = 4'h0;
            end
        end else begin
            if (m_idle < T) m_idle++;
            if (m_idle == T) begin
                m_stall = 1;
                m_mask = 4'h0;
            end
        end
    endtask

    task automatic apply(input logic r, input logic [3:0] d, input logic [6:0] p);
        @(negedge clk);
        rst      = r;
        digit_in = d;
        seg_in   = {p, 1'($urandom)};
        @(posedge clk);
        model_edge(r, d, p);
        #1;
        check_eq("chars",         chars,         m_chars);
        check_eq("frame_valid",   frame_valid,   m_fv);
        check_eq("frame_changed", frame_changed, m_fc);
        check_eq("bad_pattern",   bad_pattern,   m_bp);
        check_eq("scan_stall",    scan_stall,    m_stall);
        fv_seen += int'(frame_valid);
        fc_seen += int'(frame_changed);
        bp_seen += int'(bad_pattern);
    endtask

    task automatic dwell(input logic [3:0] d, input logic [6:0] p, input int n);
        repeat (n) apply(1'b0, d, p);
    endtask

    // Slots 0..3 in order; arguments listed digit3 first.
    task automatic scan(input logic [6:0] p3, input logic [6:0] p2,
                        input logic [6:0] p1, input logic [6:0] p0, input int n);
        dwell(4'b0001, p0, n);
        dwell(4'b0010, p1, n);
        dwell(4'b0100, p2, n);
        dwell(4'b1000, p3, n);
    endtask

    task automatic clear_seen();
        fv_seen = 0; fc_seen = 0; bp_seen = 0;
    endtask

    initial begin
        logic [6:0] rp [4];
        logic [3:0] jd;
        rst = 1'b1; digit_in = 4'h0; seg_in = 8'hFF;
        clear_seen();
        for (int i = 0; i < 4; i++) m_stage[i] = 5'h10;
        apply(1'b1, 4'h0, PB);
        apply(1'b1, 4'h0, PB);
        check_eq("reset_chars", chars, 20'h84210);

        // Digit values 3,2,1,0 on slots 0..3, twice.
        clear_seen();
        scan(P0, P1, P2, P3, 10);
        check_eq("t1_frames", fv_seen, 1);
        check_eq("t1_changed", fc_seen, 1);
        check_eq("t1_chars", chars, 20'h00443);
        clear_seen();
        scan(P0, P1, P2, P3, 10);
        check_eq("t1_rep_frames", fv_seen, 1);
        check_eq("t1_rep_changed", fc_seen, 0);

        // Letter frames.
        clear_seen();
        scan(PR, PE, PD, PB, 10);
        check_eq("t2_rE-", chars, 20'h729F0);
        scan(PD, PN, P0, PD, 10);
        check_eq("t2_-nO-", chars, 20'h7B00F);
        scan(PB, PF, P0, PD, 10);
        check_eq("t2_FO-", chars, 20'h82C0F);
        check_eq("t2_frames", fv_seen, 3);

        // Too-short dwells and a non-one-hot digit never accept.
        clear_seen();
        repeat (3) scan(P0, P1, P2, P3, 3);
        dwell(4'b0110, P8(), 20);
        dwell(4'b0000, PB, 64);
        check_eq("t3_frames", fv_seen, 0);
        check_eq("t3_stall", scan_stall, 1'b1);

        // Partial frame discarded by a stall.
        clear_seen();
        dwell(4'b0001, P1, 10);
        dwell(4'b0010, P2, 10);
        dwell(4'b0100, P3, 10);
        dwell(4'b0000, PB, 64);
        check_eq("t4_stall", scan_stall, 1'b1);
        check_eq("t4_no_frame", fv_seen, 0);
        dwell(4'b0001, P0, 10);
        dwell(4'b0010, P0, 10);
        dwell(4'b0100, P0, 10);
        check_eq("t4_partial", fv_seen, 0);
        dwell(4'b1000, P1, 10);
        check_eq("t4_frames", fv_seen, 1);
        check_eq("t4_chars", chars, 20'h08000);

        // Unknown pattern on slot 2.
        clear_seen();
        scan(P1, PX, P2, P3, 10);
        check_eq("t5_bad", bp_seen, 1);
        check_eq("t5_slot2", chars[14:10], 5'h1F);

        // Reset mid-frame.
        dwell(4'b0001, P2, 10);
        dwell(4'b0010, P2, 10);
        apply(1'b1, 4'b0100, P2);
        check_eq("t6_chars", chars, 20'h84210);
        check_eq("t6_fv", frame_valid, 1'b0);
        clear_seen();
        dwell(4'b0100, P2, 10);
        dwell(4'b1000, P2, 10);
        check_eq("t6_partial", fv_seen, 0);
        scan(P3, P3, P3, P3, 10);
        check_eq("t6_frames", fv_seen, 1);

        // Acceptance on the same edge as timeout expiry, and one edge later.
        dwell(4'b0001, P1, 4);
        dwell(4'b0000, PB, 60);
        dwell(4'b0010, P1, 4);
        check_eq("tie_stall", scan_stall, 1'b0);
        dwell(4'b0000, PB, 61);
        dwell(4'b0100, P1, 4);
        check_eq("late_stall", scan_stall, 1'b0);

        // Randomised scans with ghosting, junk digits, stalls and resets.
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < 4; i++)
                rp[i] = ($urandom_range(9) == 0) ? 7'($urandom) : PATS[$urandom_range(16)];
            for (int i = 0; i < 4; i++) begin
                int sl;
                sl = ($urandom_range(5) == 0) ? int'($urandom_range(3)) : i;
                if ($urandom_range(3) == 0)
                    dwell(4'b0001 << sl, rp[$urandom_range(3)], $urandom_range(1, 3));
                dwell(4'b0001 << sl, rp[sl], $urandom_range(1, 9));
                if ($urandom_range(7) == 0) begin
                    jd = 4'($urandom);
                    dwell(jd, rp[i], $urandom_range(1, 6));
                end
            end
            case ($urandom_range(11))
                0: dwell(4'b0000, PB, $urandom_range(55, 75));
                1: apply(1'b1, 4'b0001, rp[0]);
                default: ;
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    function automatic logic [6:0] P8();
        return 7'b0000000;
    endfunction

endmodule
